// File: rtl/datapath_pkg.sv
// Shared constants and types for the datapath control unit: opcodes, FSM
// state encodings and the instruction field layout.
package datapath_pkg;

  localparam int NUM_REGS    = 8;
  localparam int INSTR_WIDTH = 16;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_MOV  = 2'b01;
  localparam logic [1:0] OP_ADD  = 2'b10;
  localparam logic [1:0] OP_SUB  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  // Only instr[15:8] carries meaning; the IR keeps just that field.
  localparam int FIELD_LSB = 8;
  localparam int OP_LSB    = 14;
  localparam int RX_LSB    = 11;
  localparam int RY_LSB    = 8;

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] rx;
    logic [2:0] ry;
  } ir_t;

  function automatic logic is_alu_op(input logic [1:0] op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/datapath_controller_if.sv
// Instruction request and control-strobe bundle between the controller,
// its instruction source and the datapath.
interface datapath_controller_if;
  import datapath_pkg::*;

  logic                   run;
  logic [INSTR_WIDTH-1:0] instr;
  logic                   ext_data_en;
  logic [NUM_REGS-1:0]    reg_in_en;
  logic [NUM_REGS-1:0]    reg_out_en;
  logic                   alu_reg_en;
  logic                   alu_sel;
  logic                   g_reg_en;
  logic                   alu_out_en;
  logic                   done;
  logic                   busy;

  modport master (
    input  run, instr,
    output ext_data_en, reg_in_en, reg_out_en, alu_reg_en, alu_sel,
           g_reg_en, alu_out_en, done, busy
  );

  modport slave (
    output run, instr,
    input  ext_data_en, reg_in_en, reg_out_en, alu_reg_en, alu_sel,
           g_reg_en, alu_out_en, done, busy
  );

  modport monitor (
    input run, instr, ext_data_en, reg_in_en, reg_out_en, alu_reg_en,
          alu_sel, g_reg_en, alu_out_en, done, busy
  );

endinterface

// File: rtl/datapath_controller_checker.sv
// Bus-level invariants on the controller outputs.
module datapath_controller_checker (
  input logic clk,
  input logic reset,
  datapath_controller_if.monitor bus
);

  a_bus_exclusive: assert property (@(posedge clk) disable iff (reset)
    $onehot0({bus.ext_data_en, bus.alu_out_en, bus.reg_out_en}));

  a_reg_in_onehot0: assert property (@(posedge clk) disable iff (reset)
    $onehot0(bus.reg_in_en));

  a_done_busy: assert property (@(posedge clk) disable iff (reset)
    bus.done |-> bus.busy);

endmodule

// File: rtl/datapath_controller_decoder.sv
// 3-bit register index to one-hot enable; all zeros when not enabled.
module reg_onehot_decoder
  import datapath_pkg::*;
(
  input  logic [2:0]          idx,
  input  logic                en,
  output logic [NUM_REGS-1:0] onehot
);

  // Shift a single set bit into the indexed position.
  always_comb begin
    onehot = '0;
    if (en) begin
      onehot = {{(NUM_REGS-1){1'b0}}, 1'b1} << idx;
    end else begin
      onehot = '0;
    end
  end

endmodule

// File: rtl/datapath_controller.sv
// Timestep FSM that latches one instruction on run and sequences the
// datapath strobes through T1..T3, pulsing done on the final step.
module datapath_controller
  import datapath_pkg::*;
(
  input  logic clk,
  input  logic reset,
  datapath_controller_if.master bus
);

  logic [1:0]          state_q, state_d;
  ir_t                 ir_q, ir_d;
  logic [NUM_REGS-1:0] rx_oh_s, ry_oh_s;
  logic                dec_en_s;
  logic                unused_instr_s;

  logic                ext_data_en_s, alu_reg_en_s, alu_sel_s;
  logic                g_reg_en_s, alu_out_en_s, done_s, busy_s;
  logic [NUM_REGS-1:0] reg_in_en_s, reg_out_en_s;

  assign unused_instr_s = ^bus.instr[FIELD_LSB-1:0];

  // Next-state and instruction capture; instr is only sampled in IDLE.
  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    case (state_q)
      S_IDLE: begin
        if (bus.run) begin
          state_d = S_T1;
          ir_d    = ir_t'(bus.instr[INSTR_WIDTH-1:FIELD_LSB]);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T1: begin
        if (is_alu_op(ir_q.op)) begin
          state_d = S_T2;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_T2:    state_d = S_T3;
      S_T3:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // State and IR registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  assign dec_en_s = (state_q != S_IDLE);

  reg_onehot_decoder u_rx_dec (.idx(ir_q.rx), .en(dec_en_s), .onehot(rx_oh_s));
  reg_onehot_decoder u_ry_dec (.idx(ir_q.ry), .en(dec_en_s), .onehot(ry_oh_s));

  // Strobe decode from state and IR only.
  always_comb begin
    ext_data_en_s = 1'b0;
    reg_in_en_s   = '0;
    reg_out_en_s  = '0;
    alu_reg_en_s  = 1'b0;
    alu_sel_s     = 1'b0;
    g_reg_en_s    = 1'b0;
    alu_out_en_s  = 1'b0;
    done_s        = 1'b0;
    busy_s        = (state_q != S_IDLE);
    case (state_q)
      S_T1: begin
        case (ir_q.op)
          OP_LOAD: begin
            ext_data_en_s = 1'b1;
            reg_in_en_s   = rx_oh_s;
            done_s        = 1'b1;
          end
          OP_MOV: begin
            reg_out_en_s = ry_oh_s;
            reg_in_en_s  = rx_oh_s;
            done_s       = 1'b1;
          end
          default: begin
            reg_out_en_s = rx_oh_s;
            alu_reg_en_s = 1'b1;
          end
        endcase
      end
      S_T2: begin
        reg_out_en_s = ry_oh_s;
        g_reg_en_s   = 1'b1;
        alu_sel_s    = ir_q.op[0];
      end
      S_T3: begin
        alu_out_en_s = 1'b1;
        reg_in_en_s  = rx_oh_s;
        done_s       = 1'b1;
      end
      default: begin
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.ext_data_en = ext_data_en_s;
  assign bus.reg_in_en   = reg_in_en_s;
  assign bus.reg_out_en  = reg_out_en_s;
  assign bus.alu_reg_en  = alu_reg_en_s;
  assign bus.alu_sel     = alu_sel_s;
  assign bus.g_reg_en    = g_reg_en_s;
  assign bus.alu_out_en  = alu_out_en_s;
  assign bus.done        = done_s;
  assign bus.busy        = busy_s;

endmodule

// File: tb/tb_datapath_controller.sv
// Randomized bench for datapath_controller against a queue-based model of
// the per-instruction strobe schedule, plus literal checks of key cycles.
module tb_datapath_controller;

  logic clk = 1'b0;
  logic reset;
  int   compared = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  datapath_controller_if bus ();

  datapath_controller u_dut (.clk(clk), .reset(reset), .bus(bus));
  datapath_controller_checker u_chk (.clk(clk), .reset(reset), .bus(bus));

  // Vector layout: {ext, reg_in[7:0], reg_out[7:0], alu_reg, sel, g, alu_out, done, busy}
  logic [22:0] exp_q[$];
  logic [22:0] cur = 23'h0;

  function automatic logic [22:0] mk(input logic ext, input logic [7:0] rin,
                                     input logic [7:0] rout, input logic areg,
                                     input logic sel, input logic g,
                                     input logic aout, input logic dn);
    return {ext, rin, rout, areg, sel, g, aout, dn, 1'b1};
  endfunction

  function automatic logic [7:0] oh(input logic [2:0] idx);
    return 8'h01 << idx;
  endfunction

  function automatic logic [22:0] dut_vec();
    return {bus.ext_data_en, bus.reg_in_en, bus.reg_out_en, bus.alu_reg_en,
            bus.alu_sel, bus.g_reg_en, bus.alu_out_en, bus.done, bus.busy};
  endfunction

  // Model: an accepted instruction expands into its list of per-cycle outputs.
  task automatic model_edge(input logic r, input logic rn, input logic [15:0] ins);
    logic [1:0] op;
    logic [2:0] rx, ry;
    op = ins[15:14];
    rx = ins[13:11];
    ry = ins[10:8];
    if (r) begin
      exp_q.delete();
      cur = 23'h0;
    end else if (!cur[0] && rn) begin
      case (op)
        2'b00: exp_q.push_back(mk(1'b1, oh(rx), 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        2'b01: exp_q.push_back(mk(1'b0, oh(rx), oh(ry), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1));
        default: begin
          exp_q.push_back(mk(1'b0, 8'h00, oh(rx), 1'b1, 1'b0, 1'b0, 1'b0, 1'b0));
          exp_q.push_back(mk(1'b0, 8'h00, oh(ry), 1'b0, op[0], 1'b1, 1'b0, 1'b0));
          exp_q.push_back(mk(1'b0, oh(rx), 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1));
        end
      endcase
      cur = exp_q.pop_front();
    end else if (exp_q.size() > 0) begin
      cur = exp_q.pop_front();
    end else begin
      cur = 23'h0;
    end
  endtask

  task automatic step(input logic r, input logic rn, input logic [15:0] ins);
    reset     = r;
    bus.run   = rn;
    bus.instr = ins;
    @(posedge clk);
    model_edge(r, rn, ins);
    @(negedge clk);
    compared++;
    if (dut_vec() !== cur) begin
      mismatched++;
      $display("FAIL model_cmp t=%0t got=%06h expected=%06h", $time, dut_vec(), cur);
    end
  endtask

  task automatic lit(input string name, input logic [22:0] expv);
    compared++;
    if (dut_vec() !== expv) begin
      mismatched++;
      $display("FAIL %s got=%06h expected=%06h", name, dut_vec(), expv);
    end
    compared++;
    if (cur !== expv) begin
      mismatched++;
      $display("FAIL %s_model got=%06h expected=%06h", name, cur, expv);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.run = 1'b0;
    bus.instr = 16'h0000;

    step(1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h8900);
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b0, 16'h0000);
      lit("reset_idle", 23'h0);
    end

    // LOAD R0
    step(1'b0, 1'b1, 16'h0000);
    lit("load_r0", {1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step(1'b0, 1'b0, 16'h0000);
    lit("load_after", 23'h0);

    // MOV R0,R1
    step(1'b0, 1'b1, 16'h4100);
    lit("mov_r0_r1", {1'b0, 8'h01, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step(1'b0, 1'b0, 16'h0000);

    // ADD R1,R1
    step(1'b0, 1'b1, 16'h8900);
    lit("add_t1", {1'b0, 8'h00, 8'h02, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b0, 16'h0000);
    lit("add_t2", {1'b0, 8'h00, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b0, 16'h0000);
    lit("add_t3", {1'b0, 8'h02, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    step(1'b0, 1'b0, 16'h0000);

    // SUB R3,R2 with run held and instr changed mid-instruction
    step(1'b0, 1'b1, 16'hDA00);
    lit("sub_t1", {1'b0, 8'h00, 8'h08, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b1, 16'hDA00);
    lit("sub_t2", {1'b0, 8'h00, 8'h04, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1});
    step(1'b0, 1'b1, 16'h0000);
    lit("sub_t3", {1'b0, 8'h08, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1});
    step(1'b0, 1'b1, 16'h0000);
    lit("sub_gap", 23'h0);
    step(1'b0, 1'b1, 16'h0000);
    lit("sub_next_load", {1'b1, 8'h01, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});
    step(1'b0, 1'b0, 16'h0000);

    // Reset during T2 of ADD
    step(1'b0, 1'b1, 16'h8900);
    step(1'b0, 1'b0, 16'h0000);
    step(1'b1, 1'b1, 16'h0000);
    lit("reset_mid", 23'h0);
    step(1'b0, 1'b0, 16'h0000);
    lit("reset_mid_after", 23'h0);

    // MOV with Rx==Ry, low bits set
    step(1'b0, 1'b1, 16'h6DFF);
    lit("mov_r5_r5", {1'b0, 8'h20, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1});

    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 39) == 0) ? 1'b1 : 1'b0,
           ($urandom_range(0, 2) != 0) ? 1'b1 : 1'b0,
           16'($urandom));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/datapath_controller.md
Name: datapath_controller

Overview:
- Control unit that generates the control strobes for the 16-bit `datapath` block: `ext_data_en`, `reg_in_en`, `reg_out_en`, `alu_reg_en`, `alu_sel`, `g_reg_en` and `alu_out_en`.
- Latches one instruction on a `run` request, then sequences it through a timestep FSM (T1..T3).
- Pulses `done` on the final step.
- Sits between the instruction source and `datapath`, replacing hand-driven control vectors.

Parameters:
- NUM_REGS, 8, number of general registers; width of the one-hot `reg_in_en`/`reg_out_en` buses. Fixed at 8 for the 3-bit register fields.
- INSTR_WIDTH, 16, width of the `instr` input.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- run  in  1  request to execute `instr`; sampled only in IDLE.
- instr  in  INSTR_WIDTH  instruction word.
  - [15:14] opcode; [13:11] Rx (destination); [10:8] Ry (source).
  - [7:0] ignored.
- ext_data_en  out  1  drive external data onto the bus.
- reg_in_en  out  NUM_REGS  one-hot register load enable.
- reg_out_en  out  NUM_REGS  one-hot register bus-drive enable.
- alu_reg_en  out  1  load ALU operand register A from the bus.
- alu_sel  out  1  0 = add, 1 = subtract.
- g_reg_en  out  1  load result register G.
- alu_out_en  out  1  drive G onto the bus.
- done  out  1  one-cycle pulse in the last step of an instruction.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Opcodes:
  - 00 LOAD Rx,ext: Rx <- external data.
  - 01 MOV Rx,Ry: Rx <- Ry.
  - 10 ADD Rx,Ry: Rx <- Rx+Ry.
  - 11 SUB Rx,Ry: Rx <- Rx-Ry.
- States: IDLE, T1, T2, T3. State is binary-encoded in a register.
- Instruction register (IR): on the edge where state is IDLE and `run`=1, IR <= `instr` and state goes to T1. `instr` is not looked at any other time.
- Outputs are decoded combinationally from state and IR only, never from `run` or `instr`. Every output not listed for a state is 0.
- IDLE: all control outputs 0; busy=0.
- T1:
  - LOAD: ext_data_en=1, reg_in_en=onehot(Rx), done=1; next state IDLE.
  - MOV: reg_out_en=onehot(Ry), reg_in_en=onehot(Rx), done=1; next state IDLE.
  - ADD/SUB: reg_out_en=onehot(Rx), alu_reg_en=1; next state T2.
- T2 (ADD/SUB only): reg_out_en=onehot(Ry), g_reg_en=1, alu_sel=opcode[0]; next state T3.
- T3 (ADD/SUB only): alu_out_en=1, reg_in_en=onehot(Rx), done=1; next state IDLE.
- Latency: the first strobe is visible in the cycle after the `run` edge.
  - LOAD/MOV take 1 cycle; ADD/SUB take 3 cycles.
  - `done` is asserted in the same cycle as the final `reg_in_en` strobe.
- Back-to-back instructions: a new instruction can be accepted on the edge ending the done cycle only if the FSM is in IDLE at that edge. There is one mandatory IDLE cycle between instructions.
- `run` while busy: ignored, not queued.
- Bus exclusivity invariant: at most one of {ext_data_en, alu_out_en, any reg_out_en bit} is high in any cycle.
- `reg_in_en` and `reg_out_en` are each zero-hot or one-hot.
- MOV with Rx==Ry: both strobes name the same register; this is legal, and the controller issues them with no special case.
- Reset: at any state, including mid-instruction, reset=1 at an edge forces IDLE and IR=0.
  - All outputs are 0 in the following cycle.
  - `run` asserted together with `reset` is ignored.
- Unused `instr` bits [7:0] have no effect.

Decomposition:
- Shared package `datapath_pkg`:
  - opcode constants OP_LOAD=2'b00, OP_MOV=2'b01, OP_ADD=2'b10, OP_SUB=2'b11.
  - state encodings S_IDLE, S_T1, S_T2, S_T3.
  - instruction field bit positions.
- Sub-module `reg_onehot_decoder`: 3-bit index plus enable in, NUM_REGS one-hot out. Two instances, one for Rx and one for Ry.

Test Plan:
1. Reset held 2 cycles, then released; run=0 -> every output 0, busy=0, for 5 cycles.
2. run with instr=16'h0000 (LOAD R0) -> next cycle ext_data_en=1, reg_in_en=8'h01, done=1; the cycle after that, all 0.
3. instr=16'h4100 (MOV R0,R1) -> one cycle with reg_out_en=8'h02, reg_in_en=8'h01, done=1.
4. instr=16'h8900 (ADD R1,R1):
   - T1: reg_out_en=8'h02, alu_reg_en=1.
   - T2: reg_out_en=8'h02, g_reg_en=1, alu_sel=0.
   - T3: alu_out_en=1, reg_in_en=8'h02, done=1.
5. instr=16'hDA00 (SUB R3,R2) with `run` held high throughout and `instr` changed to 16'h0000 during T2 -> sequence:
   - T1 reg_out_en=8'h08; T2 reg_out_en=8'h04 with alu_sel=1; T3 reg_in_en=8'h08.
   - Then one IDLE cycle, then LOAD R0 starts.
6. reset asserted during T2 of an ADD -> next cycle all outputs 0, busy=0; the bus-exclusivity assertion holds across the whole test.
